// File: rtl/riscv_pc_ctrl_pkg.sv
// Shared encodings for the fetch next-PC sequencer: FSM states and the
// redirect-source index that the trap unit also decodes.
package riscv_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        PCC_BOOT = 2'd0,
        PCC_RUN  = 2'd1,
        PCC_WAIT = 2'd2
    } pcc_state_e;

    // Index of the winning redirect source; SRC_SEQ means no redirect.
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_MRET = 3'd3,
        SRC_TRAP = 3'd4
    } redir_src_e;

    // Trap/mret come from the committed path and may replace a pending target.
    function automatic logic src_is_exc(input redir_src_e src);
        return (src == SRC_TRAP) || (src == SRC_MRET);
    endfunction

endpackage

// File: rtl/riscv_pc_redir_arb.sv
// Fixed-priority redirect select: trap > mret > jmp > br_taken.
module riscv_pc_redir_arb
    import riscv_pc_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          trap,
    input  logic [DW-1:0] trap_vec,
    input  logic          mret,
    input  logic [DW-1:0] epc,
    input  logic          jmp,
    input  logic [DW-1:0] jmp_target,
    input  logic          br_taken,
    input  logic [DW-1:0] br_target,
    output logic          valid,
    output redir_src_e    src,
    output logic [DW-1:0] target
);

    // Highest asserted source wins; no source means sequential fetch.
    always_comb begin
        valid  = 1'b1;
        src    = SRC_SEQ;
        target = '0;
        if (trap) begin
            src    = SRC_TRAP;
            target = trap_vec;
        end else if (mret) begin
            src    = SRC_MRET;
            target = epc;
        end else if (jmp) begin
            src    = SRC_JMP;
            target = jmp_target;
        end else if (br_taken) begin
            src    = SRC_BR;
            target = br_target;
        end else begin
            valid  = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_pc_ctrl.sv
// Next-PC sequencer for fetch: boot hold-off, imem req/ack handshake,
// redirect arbitration, and capture/replay of redirects seen while stalled.
// Optional: RISCV_PC_CTRL_MISALIGN_CHK_EN adds misalign_o and drops
// jmp/br redirects whose target is not word aligned.
module riscv_pc_ctrl
    import riscv_pc_ctrl_pkg::*;
#(
    parameter int DW          = 32,
    parameter int BOOT_CYCLES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] pc_i,
    input  logic [DW-1:0] pc4_i,
    input  logic          br_taken_i,
    input  logic [DW-1:0] br_target_i,
    input  logic          jmp_i,
    input  logic [DW-1:0] jmp_target_i,
    input  logic          mret_i,
    input  logic [DW-1:0] epc_i,
    input  logic          trap_i,
    input  logic [DW-1:0] trap_vec_i,
    input  logic          hazard_stall_i,
    input  logic          imem_ack_i,
    output logic          imem_req_o,
    output logic [DW-1:0] mux_pc_o,
    output logic          stall_o,
    output logic          flush_o,
    output logic          redirect_o
`ifdef RISCV_PC_CTRL_MISALIGN_CHK_EN
    ,
    output logic          misalign_o
`endif
);

    pcc_state_e    state;
    logic [3:0]    boot_cnt;
    logic          pend_valid;
    logic [DW-1:0] pend_target;

    logic          arb_valid;
    redir_src_e    arb_src;
    logic [DW-1:0] arb_target;
    logic          in_boot;
    logic          acceptable;
    logic          take;
    logic          load_new;
    logic          load_pend;

    riscv_pc_redir_arb #(.DW(DW)) u_arb (
        .trap       (trap_i),
        .trap_vec   (trap_vec_i),
        .mret       (mret_i),
        .epc        (epc_i),
        .jmp        (jmp_i),
        .jmp_target (jmp_target_i),
        .br_taken   (br_taken_i),
        .br_target  (br_target_i),
        .valid      (arb_valid),
        .src        (arb_src),
        .target     (arb_target)
    );

    assign in_boot    = (state == PCC_BOOT);
    assign imem_req_o = (state == PCC_WAIT) | ((state == PCC_RUN) & ~hazard_stall_i);
    assign stall_o    = in_boot | hazard_stall_i | (imem_req_o & ~imem_ack_i);

    // While a target is pending, jmp/br are wrong-path and dropped.
    assign acceptable = ~in_boot & arb_valid &
                        (~stall_o | ~pend_valid | src_is_exc(arb_src));

`ifdef RISCV_PC_CTRL_MISALIGN_CHK_EN
    assign misalign_o = acceptable & ((arb_src == SRC_JMP) | (arb_src == SRC_BR)) &
                        (arb_target[1:0] != 2'b00);
    assign take       = acceptable & ~misalign_o;
`else
    assign take       = acceptable;
`endif

    assign flush_o    = take;
    assign load_new   = take & ~stall_o;
    assign load_pend  = ~stall_o & ~take & pend_valid;
    assign redirect_o = load_new | load_pend;

    // Next-PC select: hold when stalled, else new redirect, pending, sequential.
    always_comb begin
        mux_pc_o = pc4_i;
        if (stall_o)        mux_pc_o = pc_i;
        else if (load_new)  mux_pc_o = arb_target;
        else if (pend_valid) mux_pc_o = pend_target;
    end

    // Pending redirect: capture while stalled, drop once the PC moves.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (take && stall_o) begin
            pend_valid  <= 1'b1;
            pend_target <= arb_target;
        end else if (!stall_o) begin
            pend_valid  <= 1'b0;
        end
    end

    // Fetch FSM: boot hold-off, then request/ack sequencing.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= PCC_BOOT;
            boot_cnt <= 4'd0;
        end else begin
            case (state)
                PCC_BOOT: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == 4'(BOOT_CYCLES - 1)) state <= PCC_RUN;
                end
                PCC_RUN:  if (imem_req_o && !imem_ack_i) state <= PCC_WAIT;
                PCC_WAIT: if (imem_ack_i) state <= PCC_RUN;
                default:  state <= PCC_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_pc_ctrl.sv
// Self-checking bench for riscv_pc_ctrl: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_riscv_pc_ctrl;

    localparam int DW   = 32;
    localparam int BOOT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pc, pc4, br_t, jmp_t, epc, tvec;
    logic          br, jmp, mret, trap, hz, ack;
    logic          req, stall, flush, redir;
    logic [DW-1:0] mux_pc;
`ifdef RISCV_PC_CTRL_MISALIGN_CHK_EN
    logic          misalign;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    int            boot_left;
    bit            waiting;
    logic [DW-1:0] pendq[$];
    logic [DW-1:0] pc_reg;

    always #5 clk = ~clk;

    riscv_pc_ctrl #(.DW(DW), .BOOT_CYCLES(BOOT)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .pc_i           (pc),
        .pc4_i          (pc4),
        .br_taken_i     (br),
        .br_target_i    (br_t),
        .jmp_i          (jmp),
        .jmp_target_i   (jmp_t),
        .mret_i         (mret),
        .epc_i          (epc),
        .trap_i         (trap),
        .trap_vec_i     (tvec),
        .hazard_stall_i (hz),
        .imem_ack_i     (ack),
        .imem_req_o     (req),
        .mux_pc_o       (mux_pc),
        .stall_o        (stall),
        .flush_o        (flush),
        .redirect_o     (redir)
`ifdef RISCV_PC_CTRL_MISALIGN_CHK_EN
        ,
        .misalign_o     (misalign)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_redirects();
        br = 0; jmp = 0; mret = 0; trap = 0;
        br_t = '0; jmp_t = '0; epc = '0; tvec = '0;
    endtask

    // Expected outputs of the last tick, kept for directed spot checks.
    logic [DW-1:0] e_mux;
    logic          e_flush, e_redir, e_stall, e_req;

    // Evaluate one cycle: inputs already driven just after a negedge.
    task automatic tick();
        bit            booting, has, exc, accepted, mis;
        logic [DW-1:0] tgt;
        logic          en [4];
        logic [DW-1:0] tg [4];
        pc  = pc_reg;
        pc4 = pc_reg + 32'd4;
        #1;
        booting = (boot_left > 0);
        e_req   = booting ? 1'b0 : (waiting ? 1'b1 : !hz);
        e_stall = booting || hz || (e_req && !ack);
        en = '{trap, mret, jmp, br};
        tg = '{tvec, epc, jmp_t, br_t};
        has = 0; exc = 0; tgt = '0;
        for (int i = 0; i < 4; i++) begin
            if (!has && en[i]) begin
                has = 1; exc = (i < 2); tgt = tg[i];
            end
        end
        accepted = !booting && has && (!e_stall || pendq.size() == 0 || exc);
        mis = 0;
`ifdef RISCV_PC_CTRL_MISALIGN_CHK_EN
        mis = accepted && !exc && (tgt[1:0] != 2'b00);
        chk("misalign", misalign, mis);
`endif
        if (mis) accepted = 0;
        e_flush = accepted;
        if (e_stall)                 e_mux = pc;
        else if (accepted)           e_mux = tgt;
        else if (pendq.size() != 0)  e_mux = pendq[0];
        else                         e_mux = pc4;
        e_redir = !e_stall && (accepted || pendq.size() != 0);

        chk("imem_req", req, e_req);
        chk("stall", stall, e_stall);
        chk("flush", flush, e_flush);
        chk("redirect", redir, e_redir);
        chk("mux_pc", mux_pc, e_mux);

        // Advance model to the next cycle.
        if (accepted && e_stall) begin
            pendq.delete();
            pendq.push_back(tgt);
        end else if (!e_stall) begin
            pendq.delete();
        end
        if (booting)               boot_left--;
        else if (waiting)          waiting = !ack;
        else if (e_req && !ack)    waiting = 1;
        pc_reg = e_mux;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_redirects();
        hz = 0; ack = 0;
        pc = '0; pc4 = 32'd4;
        #1;
        chk("rst_stall", stall, 1'b1);
        chk("rst_req", req, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_redirect", redir, 1'b0);
        chk("rst_mux", mux_pc, '0);
        boot_left = BOOT; waiting = 0; pendq.delete(); pc_reg = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clr_redirects();
        hz = 0; ack = 0; pc = '0; pc4 = '0;
        @(negedge clk);
        do_reset();

        // Boot: two held cycles, then a fetch with ack loads pc+4.
        ack = 1;
        tick(); chk("boot1_req", e_req, 1'b0);
        tick();
        tick(); chk("boot_pc4", mux_pc === 32'd4 ? 32'd4 : mux_pc, 32'd4);

        // Branch with ack in RUN.
        pc_reg = 32'h100;
        br = 1; br_t = 32'h200;
        tick(); chk("br_target", e_mux, 32'h200);
        clr_redirects();

        // Trap beats jmp in the same cycle.
        trap = 1; tvec = 32'h80; jmp = 1; jmp_t = 32'h300;
        tick(); chk("trap_prio", e_mux, 32'h80);
        clr_redirects();

        // Hazard stall: jmp captured, later br ignored, replay on release.
        hz = 1; ack = 0; jmp = 1; jmp_t = 32'h400;
        tick(); chk("hz_flush1", e_flush, 1'b1);
        clr_redirects(); br = 1; br_t = 32'h500;
        tick(); chk("hz_flush2", e_flush, 1'b0);
        clr_redirects();
        tick();
        hz = 0; ack = 1;
        tick(); chk("hz_replay", e_mux, 32'h400); chk("hz_replay_fl", e_flush, 1'b0);

        // WAIT_ACK with a trap arriving mid-wait, replayed on the ack cycle.
        ack = 0;
        tick();
        tick();
        trap = 1; tvec = 32'h80;
        tick(); clr_redirects();
        tick();
        ack = 1;
        tick(); chk("wait_replay", e_mux, 32'h80);

        // Randomized traffic with occasional asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
            end
            hz    = ($urandom_range(99) < 25);
            ack   = ($urandom_range(99) < 55);
            br    = ($urandom_range(99) < 20);
            jmp   = ($urandom_range(99) < 15);
            mret  = ($urandom_range(99) < 6);
            trap  = ($urandom_range(99) < 6);
            br_t  = $urandom & 32'hFFFF_FFFC;
            jmp_t = ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            epc   = $urandom & 32'hFFFF_FFFC;
            tvec  = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_pc_ctrl.md
Name: riscv_pc_ctrl

Overview:
- Next-PC sequencer for the fetch stage. Drives the PC register's next-value mux input and stall input.
- Arbitrates between sequential, branch, jump, mret and trap redirects, with a fixed priority.
- Holds a redirect that arrives while the pipeline is stalled and replays it when the stall releases.
- Sequences the instruction-memory request/ack handshake and raises a one-cycle pipeline flush on every accepted redirect.

Parameters:
- DW, 32, datapath/PC width in bits.
- BOOT_CYCLES, 2, cycles after reset release during which fetch is held off; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- pc_i  in  DW  current PC from the PC register.
- pc4_i  in  DW  PC+4 from the PC register.
- br_taken_i  in  1  branch resolved taken this cycle.
- br_target_i  in  DW  branch target.
- jmp_i  in  1  JAL/JALR resolved this cycle.
- jmp_target_i  in  DW  jump target.
- mret_i  in  1  return from trap.
- epc_i  in  DW  saved exception PC.
- trap_i  in  1  trap taken.
- trap_vec_i  in  DW  trap vector.
- hazard_stall_i  in  1  stall request from the hazard unit.
- imem_ack_i  in  1  instruction memory has returned the fetch.
- imem_req_o  out  1  fetch request.
- mux_pc_o  out  DW  next PC, to the PC register.
- stall_o  out  1  hold the PC register.
- flush_o  out  1  kill the IF/ID stages.
- redirect_o  out  1  a non-sequential PC is being loaded this cycle.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=BOOT, boot counter=0, pend_valid=0, pend_target=0.
  - Outputs: stall_o=1, imem_req_o=0, flush_o=0, redirect_o=0, mux_pc_o=0.
- Redirect priority, highest first: trap > mret > jmp > br_taken > sequential (pc4_i). The "new redirect" is the highest asserted source.
- FSM states: BOOT, RUN, WAIT_ACK.
  - BOOT:
    - stall_o=1, imem_req_o=0.
    - The counter increments each cycle; at BOOT_CYCLES-1 go to RUN.
    - Redirect inputs are ignored.
  - RUN:
    - imem_req_o=1 unless hazard_stall_i=1.
    - If imem_ack_i=1 in the same cycle, stay in RUN and load the next PC.
    - Otherwise go to WAIT_ACK.
  - WAIT_ACK:
    - imem_req_o=1, stall_o=1.
    - On imem_ack_i=1, return to RUN; the PC advances that cycle.
- stall_o = (state==BOOT) | hazard_stall_i | (imem_req_o & ~imem_ack_i).
- When stall_o=0, mux_pc_o is chosen in this order:
  1. new redirect target, if a redirect is asserted;
  2. else pend_target, if pend_valid=1 (pend_valid then clears);
  3. else pc4_i.
- When stall_o=1, mux_pc_o=pc_i.
- Redirect while stalled:
  - The target is captured into pend_target and pend_valid is set.
  - flush_o pulses in the capture cycle.
  - While pend_valid=1, only trap or mret overwrite the pending target. jmp/br come from the wrong path and are ignored: no flush, no capture.
  - A trap arriving with a pending trap overwrites it (the later one wins).
- flush_o=1 for exactly one cycle per accepted redirect, whether loaded directly or captured.
- redirect_o=1 in the cycle mux_pc_o carries a non-sequential target with stall_o=0, including a pending replay. No flush is issued on replay.
- A redirect in the same cycle as imem_ack_i with no stall loads directly; no pend is used.
- A redirect arriving during WAIT_ACK is captured and replayed on the ack cycle.
- Reset mid-operation: all state clears asynchronously and any pending redirect is discarded.
- Width: all targets are DW bits; no arithmetic is performed here (pc4_i is supplied externally).

Optional Feature:
- Macro: RISCV_PC_CTRL_MISALIGN_CHK_EN.
- Defined:
  - Adds output misalign_o (1 bit).
  - misalign_o=1 for one cycle when an accepted jmp/br target has bits [1:0]!=0.
  - That redirect is suppressed: no flush, no capture. The trap unit is expected to respond with trap_i.
- Undefined: no port is added and targets are loaded unchecked.

Decomposition:
- Shared define header:
  - state encodings: PCC_BOOT=2'd0, PCC_RUN=2'd1, PCC_WAIT=2'd2;
  - redirect-source encoding (3-bit one-hot-to-index) reused by the trap unit;
  - existing `dw/`ZERO usage.
- One natural sub-module: riscv_pc_redir_arb, a combinational priority select producing {valid, src, target}. The FSM, pending register and handshake stay in the top.

Test Plan:
- Reset release with BOOT_CYCLES=2 -> stall_o=1 and imem_req_o=0 for 2 cycles; cycle 3: imem_req_o=1; with ack, mux_pc_o=pc4_i=0x4.
- RUN, pc_i=0x100, br_taken_i=1, br_target_i=0x200, ack=1 -> mux_pc_o=0x200, flush_o=1, redirect_o=1 for one cycle.
- trap_i=1 (vec 0x80) with jmp_i=1 (0x300) in the same cycle -> mux_pc_o=0x80, a single flush.
- hazard_stall_i=1 for 3 cycles, jmp to 0x400 in cycle 1, br to 0x500 in cycle 2 -> flush in cycle 1 only; on release, mux_pc_o=0x400, redirect_o=1, flush_o=0.
- WAIT_ACK with ack delayed 4 cycles, trap to 0x80 arriving mid-wait -> stall_o=1 throughout; on the ack cycle, mux_pc_o=0x80.
- With RISCV_PC_CTRL_MISALIGN_CHK_EN defined, jmp target 0x202 -> misalign_o=1, flush_o=0, mux_pc_o=pc4_i.
